menu_select: RTL and testbench

MENU_SELECT -- requirements
Module: menu_select

---
 rtl/menu_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/menu_select.sv | 70 +++++++
 tb/tb_menu_select.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared constants, state encoding and cursor-step helper for the battle menu.
// Define MENU_SELECT_WRAP_EN to make the cursor wrap at both ends instead of saturating.
package menu_pkg;

  localparam int unsigned N_ITEMS = 4;

  localparam logic [1:0] POS_FIGHT = 2'd0;
  localparam logic [1:0] POS_ACT   = 2'd1;
  localparam logic [1:0] POS_ITEM  = 2'd2;
  localparam logic [1:0] POS_MERCY = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t BROWSE  = 2'd1;
  localparam state_t PENDING = 2'd2;

  function automatic logic [1:0] step_pos(input logic [1:0] pos, input logic up);
    logic [1:0] nxt;
`ifdef MENU_SELECT_WRAP_EN
    nxt = up ? pos + 2'd1 : pos - 2'd1;
`else
    if (up) nxt = (pos == 2'(N_ITEMS - 1)) ? pos : pos + 2'd1;
    else    nxt = (pos == POS_FIGHT) ? pos : pos - 2'd1;
`endif
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> counting debouncer -> one-cycle press on rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // flip on the DEBOUNCE_CYCLES-th consecutive differing cycle
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // combinational edge keeps raw-to-output latency at DEBOUNCE_CYCLES+3
  assign press = level & ~level_q;

endmodule

// File: rtl/menu_select.sv
// Battle-menu cursor/selection FSM fed by three debounced board buttons.
// Define MENU_SELECT_WRAP_EN for a wrapping cursor (default saturates).
module menu_select
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RESET_POS       = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_confirm,
  input  logic       i_sel_ack,
  output logic [1:0] o_cursor_position,
  output logic       o_sel_valid,
  output logic [1:0] o_sel_id
);

  logic   press_left;
  logic   press_right;
  logic   press_confirm;
  state_t state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(i_clk), .rst_n(i_rst_n), .raw(i_btn_left), .press(press_left)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(i_clk), .rst_n(i_rst_n), .raw(i_btn_right), .press(press_right)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clk(i_clk), .rst_n(i_rst_n), .raw(i_btn_confirm), .press(press_confirm)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      o_cursor_position <= 2'(RESET_POS);
      o_sel_valid       <= 1'b0;
      o_sel_id          <= '0;
    end else if (!i_enable) begin
      state       <= IDLE;
      o_sel_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= BROWSE;
        BROWSE: begin
          if (press_confirm) begin
            state       <= PENDING;
            o_sel_valid <= 1'b1;
            o_sel_id    <= o_cursor_position;
          end else if (press_left ^ press_right) begin
            o_cursor_position <= step_pos(o_cursor_position, press_right);
          end
        end
        PENDING: begin
          if (i_sel_ack) begin
            state       <= BROWSE;
            o_sel_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_select.sv
// Directed bench for menu_select with DEBOUNCE_CYCLES=4; follows MENU_SELECT_WRAP_EN for boundary expectations.
module tb_menu_select;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       btn_left;
  logic       btn_right;
  logic       btn_confirm;
  logic       sel_ack;
  logic [1:0] cursor;
  logic       sel_valid;
  logic [1:0] sel_id;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [1:0]  exp_pos;

  menu_select #(.DEBOUNCE_CYCLES(4), .RESET_POS(0)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_enable          (enable),
    .i_btn_left        (btn_left),
    .i_btn_right       (btn_right),
    .i_btn_confirm     (btn_confirm),
    .i_sel_ack         (sel_ack),
    .o_cursor_position (cursor),
    .o_sel_valid       (sel_valid),
    .o_sel_id          (sel_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bench's own cursor model, independent of the RTL helper.
  function automatic logic [1:0] model_step(input logic [1:0] p, input logic up);
`ifdef MENU_SELECT_WRAP_EN
    if (up) return (p == 2'd3) ? 2'd0 : p + 2'd1;
    else    return (p == 2'd0) ? 2'd3 : p - 2'd1;
`else
    if (up) return (p == 2'd3) ? 2'd3 : p + 2'd1;
    else    return (p == 2'd0) ? 2'd0 : p - 2'd1;
`endif
  endfunction

  // b[0]=left b[1]=right b[2]=confirm; held 8 cycles then released 8 cycles
  task automatic press(input logic [2:0] b);
    btn_left    = b[0];
    btn_right   = b[1];
    btn_confirm = b[2];
    tick(8);
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    btn_confirm = 1'b0;
    tick(8);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sel_ack = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_confirm = 1'b0;
    tick(3);
    check("rst_cursor", cursor, 0);
    check("rst_valid", sel_valid, 0);
    check("rst_id", sel_id, 0);
    exp_pos = 2'd0;

    // Enable, then hold right 10 cycles: move exactly 7 edges after the rise
    rst_n = 1'b1; enable = 1'b1;
    tick(1);
    btn_right = 1'b1;
    tick(6);
    check("lat_before", cursor, 0);
    tick(1);
    check("lat_at7", cursor, 1);
    tick(3);
    check("held_no_repeat", cursor, 1);
    btn_right = 1'b0;
    tick(10);
    check("after_release", cursor, 1);
    exp_pos = 2'd1;

    // 3-high / 3-low glitches never satisfy a 4-cycle debounce
    for (int i = 0; i < 4; i++) begin
      btn_right = 1'b1; tick(3);
      btn_right = 1'b0; tick(3);
    end
    tick(8);
    check("glitch", cursor, exp_pos);

    // Upper boundary
    for (int i = 0; i < 4 && exp_pos != 2'd3; i++) begin
      press(3'b010); exp_pos = model_step(exp_pos, 1'b1);
    end
    check("reach3", cursor, 3);
    press(3'b010); exp_pos = model_step(exp_pos, 1'b1);
    check("right_at3", cursor, exp_pos);

    // Lower boundary
    for (int i = 0; i < 4 && exp_pos != 2'd0; i++) begin
      press(3'b001); exp_pos = model_step(exp_pos, 1'b0);
    end
    check("reach0", cursor, 0);
    press(3'b001); exp_pos = model_step(exp_pos, 1'b0);
    check("left_at0", cursor, exp_pos);

    // Confirm at position 2, ignore presses while pending, then ack
    for (int i = 0; i < 4 && exp_pos != 2'd2; i++) begin
      press(3'b010); exp_pos = model_step(exp_pos, 1'b1);
    end
    check("reach2", cursor, 2);
    press(3'b100);
    check("conf_valid", sel_valid, 1);
    check("conf_id", sel_id, 2);
    press(3'b001);
    check("pend_left_pos", cursor, 2);
    check("pend_left_valid", sel_valid, 1);
    check("pend_left_id", sel_id, 2);
    tick(5);
    sel_ack = 1'b1;
    tick(1);
    sel_ack = 1'b0;
    check("ack_valid", sel_valid, 0);
    check("ack_pos", cursor, 2);
    press(3'b010); exp_pos = model_step(exp_pos, 1'b1);
    check("browse_after_ack", cursor, 3);
    press(3'b001); exp_pos = model_step(exp_pos, 1'b0);
    check("back_to2", cursor, 2);

    // Ack outside PENDING does nothing
    sel_ack = 1'b1; tick(2); sel_ack = 1'b0;
    check("stray_ack_valid", sel_valid, 0);

    // Simultaneous left+right cancels; confirm beats a move
    press(3'b011);
    check("lr_cancel", cursor, 2);
    press(3'b110);
    check("cr_valid", sel_valid, 1);
    check("cr_id", sel_id, 2);
    check("cr_pos", cursor, 2);

    // Disable while pending: valid drops on the next edge, cursor kept
    enable = 1'b0;
    tick(1);
    check("dis_valid", sel_valid, 0);
    check("dis_pos", cursor, 2);

    // Presses while idle are dropped
    press(3'b010);
    enable = 1'b1;
    tick(12);
    check("idle_discard", cursor, 2);
    check("idle_no_valid", sel_valid, 0);

    // Reset while pending
    press(3'b100);
    check("pend2_valid", sel_valid, 1);
    rst_n = 1'b0;
    tick(1);
    check("pend_rst_pos", cursor, 0);
    check("pend_rst_valid", sel_valid, 0);
    check("pend_rst_id", sel_id, 0);
    rst_n = 1'b1;
    tick(2);

    // Reset mid-debounce abandons the press
    btn_right = 1'b1;
    tick(4);
    rst_n = 1'b0;
    btn_right = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(12);
    check("mid_deb_rst_pos", cursor, 0);
    check("mid_deb_rst_valid", sel_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
